puf_soc_ro_ctrl: RTL and testbench

Sequencer for the ring-oscillator PUF bank. On a start pulse it walks the bank pair by pair. For each pair it enables RO 2k and RO 2k+1, counts their rising edges over a fixed window, and compares the counts to produce response bit k. The block sits between the SoC register interface (start/response/valid) and the RO bank's enable/output vectors. It is the only driver of the bank enables.

---
 rtl/puf_soc_ro_ctrl.sv | 156 +++++++++++++++
 tb/tb_puf_soc_ro_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/puf_soc_ro_ctrl.sv
// Ring-oscillator PUF sequencer.
// Walks the RO bank one pair at a time. For each pair it settles the pair,
// counts rising edges on both ROs over a fixed window, and compares the counts
// to produce one response bit.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_start        : run request, sampled only while idle
//   o_puf_en       : RO enable vector (at most one pair high)
//   i_puf_ro       : raw RO outputs, asynchronous to i_clk
//   o_busy         : evaluation in progress
//   o_valid        : one-cycle pulse when o_resp is complete
//   o_resp         : bit k = count(RO 2k) > count(RO 2k+1)
//   o_tie          : sticky per run, set if any pair counted equal
module puf_soc_ro_ctrl #(
  parameter int unsigned PUF_LENGTH    = 16,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned WINDOW_CYCLES = 1024,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  output logic [PUF_LENGTH-1:0]   o_puf_en,
  input  logic [PUF_LENGTH-1:0]   i_puf_ro,
  output logic                    o_busy,
  output logic                    o_valid,
  output logic [PUF_LENGTH/2-1:0] o_resp,
  output logic                    o_tie
);

  localparam int unsigned NPAIR   = PUF_LENGTH / 2;
  localparam int unsigned K_W     = (NPAIR > 1) ? $clog2(NPAIR) : 1;
  localparam int unsigned TMR_MAX = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_COUNT, S_COMPARE, S_DONE
  } state_t;

  state_t                  r_state;
  logic [PUF_LENGTH-1:0]   r_sync1;
  logic [PUF_LENGTH-1:0]   r_sync2;
  logic [PUF_LENGTH-1:0]   r_dly;
  logic [K_W-1:0]          r_k;
  logic [TMR_W-1:0]        r_tmr;
  logic [CNT_W-1:0]        r_cnt_a;
  logic [CNT_W-1:0]        r_cnt_b;
  logic [PUF_LENGTH-1:0]   r_puf_en;
  logic                    r_busy;
  logic                    r_valid;
  logic [NPAIR-1:0]        r_resp;
  logic                    r_tie;

  logic [PUF_LENGTH-1:0]   w_rise;
  logic [PUF_LENGTH-1:0]   w_pair_mask;
  logic [K_W:0]            w_idx_a;
  logic [K_W:0]            w_idx_b;
  logic                    w_rise_a;
  logic                    w_rise_b;
  logic                    w_run;

  // Per-RO 2-flop synchronizer followed by an edge-detect delay flop
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_dly   <= '0;
    end else begin
      r_sync1 <= i_puf_ro;
      r_sync2 <= r_sync1;
      r_dly   <= r_sync2;
    end
  end

  assign w_rise      = r_sync2 & ~r_dly;
  assign w_idx_a     = {r_k, 1'b0};
  assign w_idx_b     = {r_k, 1'b1};
  assign w_rise_a    = w_rise[w_idx_a];
  assign w_rise_b    = w_rise[w_idx_b];
  assign w_pair_mask = PUF_LENGTH'(2'b11) << w_idx_a;
  assign w_run       = (r_state == S_SETTLE) || (r_state == S_COUNT) || (r_state == S_COMPARE);

  // Sequencer FSM; status outputs are registered images of the current state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_k      <= '0;
      r_tmr    <= '0;
      r_cnt_a  <= '0;
      r_cnt_b  <= '0;
      r_puf_en <= '0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_resp   <= '0;
      r_tie    <= 1'b0;
    end else begin
      r_busy   <= w_run;
      r_valid  <= (r_state == S_DONE);
      r_puf_en <= w_run ? w_pair_mask : '0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state <= S_SETTLE;
            r_k     <= '0;
            r_tmr   <= '0;
            r_resp  <= '0;
            r_tie   <= 1'b0;
          end
        end
        S_SETTLE: begin
          r_cnt_a <= '0;
          r_cnt_b <= '0;
          if (r_tmr == TMR_W'(SETTLE_CYCLES - 1)) begin
            r_tmr   <= '0;
            r_state <= S_COUNT;
          end else begin
            r_tmr <= r_tmr + TMR_W'(1);
          end
        end
        S_COUNT: begin
          // Saturating edge counters
          if (w_rise_a && (r_cnt_a != '1)) r_cnt_a <= r_cnt_a + CNT_W'(1);
          if (w_rise_b && (r_cnt_b != '1)) r_cnt_b <= r_cnt_b + CNT_W'(1);
          if (r_tmr == TMR_W'(WINDOW_CYCLES - 1)) begin
            r_tmr   <= '0;
            r_state <= S_COMPARE;
          end else begin
            r_tmr <= r_tmr + TMR_W'(1);
          end
        end
        S_COMPARE: begin
          r_resp[r_k] <= (r_cnt_a > r_cnt_b);
          if (r_cnt_a == r_cnt_b) r_tie <= 1'b1;
          if (r_k == K_W'(NPAIR - 1)) begin
            r_state <= S_DONE;
          end else begin
            r_k     <= r_k + K_W'(1);
            r_state <= S_SETTLE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_puf_en = r_puf_en;
  assign o_busy   = r_busy;
  assign o_valid  = r_valid;
  assign o_resp   = r_resp;
  assign o_tie    = r_tie;

endmodule

// File: tb/tb_puf_soc_ro_ctrl.sv
// Directed bench for puf_soc_ro_ctrl: 4 ROs, 4-bit counters, settle 3, window 60.
module tb_puf_soc_ro_ctrl;

  localparam int unsigned PL       = 4;
  localparam int unsigned NP       = PL / 2;
  localparam int unsigned SET_C    = 3;
  localparam int unsigned WIN_C    = 60;
  localparam int          PAIR_CYC = SET_C + WIN_C + 1;   // 64
  localparam int          LAT      = NP * PAIR_CYC + 1;   // 129

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [PL-1:0] ro    = '0;
  logic [PL-1:0] puf_en;
  logic          busy;
  logic          valid;
  logic [NP-1:0] resp;
  logic          tie;

  int n_checks = 0;
  int n_fail   = 0;
  int half_ns [PL] = '{default: 0};
  int ns = 0;

  puf_soc_ro_ctrl #(
    .PUF_LENGTH   (PL),
    .CNT_W        (4),
    .WINDOW_CYCLES(WIN_C),
    .SETTLE_CYCLES(SET_C)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .o_puf_en(puf_en),
    .i_puf_ro(ro),
    .o_busy  (busy),
    .o_valid (valid),
    .o_resp  (resp),
    .o_tie   (tie)
  );

  always #5 clk = ~clk;

  // Free-running RO models; transitions never coincide with a clock edge
  initial begin
    forever begin
      #1;
      ns++;
      for (int i = 0; i < PL; i++)
        ro[i] = (half_ns[i] == 0) ? 1'b0 : 1'(((ns + 2) / half_ns[i]) % 2);
    end
  end

  task automatic set_periods(input int p0, input int p1, input int p2, input int p3);
    half_ns[0] = p0 * 5;
    half_ns[1] = p1 * 5;
    half_ns[2] = p2 * 5;
    half_ns[3] = p3 * 5;
  endtask

  // Launch one run and observe it cycle by cycle; returns the valid cycle
  // (relative to the accepting edge) and the number of enable/busy deviations.
  task automatic do_run(input int pulse_a, input int pulse_b, input bit hold,
                        output int vcyc, output int en_err);
    logic [PL-1:0] exp_en;
    logic          exp_busy;
    vcyc   = 0;
    en_err = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    for (int n = 1; n <= 300 && vcyc == 0; n++) begin
      @(posedge clk); #1;
      if ((pulse_a > 0 && n == pulse_a) || (pulse_b > 0 && n == pulse_b)) start = 1'b1;
      else if ((pulse_a > 0 && n == pulse_a + 1) || (pulse_b > 0 && n == pulse_b + 1)) start = 1'b0;
      exp_en   = (n <= PAIR_CYC) ? 4'b0011 : (n <= 2 * PAIR_CYC) ? 4'b1100 : 4'b0000;
      exp_busy = (n <= 2 * PAIR_CYC);
      if (puf_en !== exp_en || busy !== exp_busy || $countones(puf_en) > 2) en_err++;
      if (valid === 1'b1) vcyc = n;
    end
  endtask

  task automatic test_reset;
    int idle_err;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (puf_en !== 4'b0000) begin n_fail++; $display("FAIL reset_en: got %b expected 0000", puf_en); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid); end
    n_checks++; if (resp !== 2'b00) begin n_fail++; $display("FAIL reset_resp: got %b expected 00", resp); end
    n_checks++; if (tie !== 1'b0) begin n_fail++; $display("FAIL reset_tie: got %b expected 0", tie); end
    @(negedge clk) rst_n = 1'b1;
    idle_err = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (busy !== 1'b0 || valid !== 1'b0 || puf_en !== 4'b0000) idle_err++;
    end
    n_checks++; if (idle_err != 0) begin n_fail++; $display("FAIL reset_idle: got %0d active cycles expected 0", idle_err); end
  endtask

  task automatic test_basic;
    int vcyc, en_err;
    set_periods(6, 10, 10, 6);
    do_run(0, 0, 1'b0, vcyc, en_err);
    n_checks++; if (vcyc != LAT) begin n_fail++; $display("FAIL basic_latency: got %0d expected %0d", vcyc, LAT); end
    n_checks++; if (en_err != 0) begin n_fail++; $display("FAIL basic_enable_seq: got %0d bad cycles expected 0", en_err); end
    n_checks++; if (resp !== 2'b01) begin n_fail++; $display("FAIL basic_resp: got %b expected 01", resp); end
    n_checks++; if (tie !== 1'b0) begin n_fail++; $display("FAIL basic_tie: got %b expected 0", tie); end
    @(posedge clk); #1;
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_pulse: got %b expected 0", valid); end
    n_checks++; if (resp !== 2'b01) begin n_fail++; $display("FAIL basic_resp_hold: got %b expected 01", resp); end
  endtask

  task automatic test_tie;
    int vcyc, en_err;
    set_periods(8, 8, 6, 10);
    do_run(0, 0, 1'b0, vcyc, en_err);
    n_checks++; if (vcyc != LAT) begin n_fail++; $display("FAIL tie_latency: got %0d expected %0d", vcyc, LAT); end
    n_checks++; if (resp !== 2'b10) begin n_fail++; $display("FAIL tie_resp: got %b expected 10", resp); end
    n_checks++; if (tie !== 1'b1) begin n_fail++; $display("FAIL tie_flag: got %b expected 1", tie); end
    repeat (5) @(posedge clk);
    #1;
    n_checks++; if (tie !== 1'b1) begin n_fail++; $display("FAIL tie_sticky: got %b expected 1", tie); end
    set_periods(6, 10, 10, 6);
    do_run(0, 0, 1'b0, vcyc, en_err);
    n_checks++; if (tie !== 1'b0) begin n_fail++; $display("FAIL tie_clear: got %b expected 0", tie); end
    n_checks++; if (resp !== 2'b01) begin n_fail++; $display("FAIL tie_clear_resp: got %b expected 01", resp); end
  endtask

  task automatic test_saturation;
    int vcyc, en_err;
    // RO0 gives ~20 edges: saturates at 15 (> 10), whereas a wrap would give ~4
    set_periods(3, 6, 6, 10);
    do_run(0, 0, 1'b0, vcyc, en_err);
    n_checks++; if (vcyc != LAT) begin n_fail++; $display("FAIL sat_latency: got %0d expected %0d", vcyc, LAT); end
    n_checks++; if (resp !== 2'b11) begin n_fail++; $display("FAIL sat_resp: got %b expected 11", resp); end
    n_checks++; if (tie !== 1'b0) begin n_fail++; $display("FAIL sat_tie: got %b expected 0", tie); end
  endtask

  task automatic test_start_busy;
    int vcyc, en_err, act;
    set_periods(6, 10, 10, 6);
    do_run(30, 2 * PAIR_CYC, 1'b0, vcyc, en_err);
    n_checks++; if (vcyc != LAT) begin n_fail++; $display("FAIL busy_start_latency: got %0d expected %0d", vcyc, LAT); end
    n_checks++; if (en_err != 0) begin n_fail++; $display("FAIL busy_start_enable_seq: got %0d bad cycles expected 0", en_err); end
    n_checks++; if (resp !== 2'b01) begin n_fail++; $display("FAIL busy_start_resp: got %b expected 01", resp); end
    act = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (busy !== 1'b0 || valid !== 1'b0) act++;
    end
    n_checks++; if (act != 0) begin n_fail++; $display("FAIL busy_start_no_restart: got %0d active cycles expected 0", act); end
  endtask

  task automatic test_back_to_back;
    int vcyc, en_err, m;
    set_periods(6, 10, 6, 10);
    do_run(0, 0, 1'b1, vcyc, en_err);
    n_checks++; if (vcyc != LAT) begin n_fail++; $display("FAIL b2b_latency1: got %0d expected %0d", vcyc, LAT); end
    n_checks++; if (resp !== 2'b11) begin n_fail++; $display("FAIL b2b_resp1: got %b expected 11", resp); end
    set_periods(10, 6, 10, 6);
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_gap: got %b expected 0", busy); end
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_restart: got %b expected 1", busy); end
    start = 1'b0;
    m = 0;
    for (int n = 1; n <= 300 && m == 0; n++) begin
      @(posedge clk); #1;
      if (valid === 1'b1) m = n;
    end
    n_checks++; if (m != LAT - 1) begin n_fail++; $display("FAIL b2b_latency2: got %0d expected %0d", m, LAT - 1); end
    n_checks++; if (resp !== 2'b00) begin n_fail++; $display("FAIL b2b_resp2: got %b expected 00", resp); end
  endtask

  task automatic test_reset_mid_run;
    int idle_err, vcyc, en_err;
    set_periods(6, 10, 10, 6);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (99) @(posedge clk);
    #1;
    n_checks++; if (resp !== 2'b01) begin n_fail++; $display("FAIL midrun_partial_resp: got %b expected 01", resp); end
    n_checks++; if (puf_en !== 4'b1100) begin n_fail++; $display("FAIL midrun_en: got %b expected 1100", puf_en); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (puf_en !== 4'b0000) begin n_fail++; $display("FAIL midrun_reset_en: got %b expected 0000", puf_en); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrun_reset_busy: got %b expected 0", busy); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL midrun_reset_valid: got %b expected 0", valid); end
    n_checks++; if (resp !== 2'b00) begin n_fail++; $display("FAIL midrun_reset_resp: got %b expected 00", resp); end
    n_checks++; if (tie !== 1'b0) begin n_fail++; $display("FAIL midrun_reset_tie: got %b expected 0", tie); end
    @(negedge clk) rst_n = 1'b1;
    idle_err = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (busy !== 1'b0 || valid !== 1'b0 || puf_en !== 4'b0000) idle_err++;
    end
    n_checks++; if (idle_err != 0) begin n_fail++; $display("FAIL midrun_idle_after: got %0d active cycles expected 0", idle_err); end
    do_run(0, 0, 1'b0, vcyc, en_err);
    n_checks++; if (vcyc != LAT || resp !== 2'b01) begin n_fail++; $display("FAIL midrun_recover: got latency %0d resp %b expected %0d 01", vcyc, resp, LAT); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tie();
    test_saturation();
    test_start_busy();
    test_back_to_back();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
